// File: rtl/dense_pkg.sv
// -----------------------------------------------------------------------------
// dense_pkg
// Shared definitions for the sequential dense (fully connected) layer:
//   - state_t     : controller state encoding (IDLE, MAC, FINAL, DONE)
//   - ACT_*       : activation mode constants for the ACT parameter
//   - acc_width() : accumulator width that cannot overflow for N_input products
//   - idx_width() : counter/index width for a given element count (min 1 bit)
// -----------------------------------------------------------------------------
package dense_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int ACT_IDENTITY = 0;
    localparam int ACT_RELU     = 1;

    // A full-precision product is 2*bitsize bits; summing n_input of them needs
    // clog2(n_input) growth bits plus one guard bit.
    function automatic int acc_width(input int bitsize, input int n_input);
        return 2 * bitsize + $clog2(n_input) + 1;
    endfunction

    // Width of a counter that indexes 'count' elements; never narrower than 1.
    function automatic int idx_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/fixed_point_mac.sv
// -----------------------------------------------------------------------------
// fixed_point_mac
// Signed multiply-accumulate unit. Each enabled cycle adds the full-precision
// product a*b to the accumulator. 'clear' starts a new sum: together with
// 'enable' the accumulator is loaded with the current product, so the first
// term of a neuron costs no extra cycle.
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   synchronous active-high reset (accumulator -> 0)
//   clear   in   discard previous sum
//   enable  in   accumulate a*b this cycle
//   a, b    in   signed BITSIZE-bit operands
//   acc     out  signed ACC_W-bit running sum
// -----------------------------------------------------------------------------
module fixed_point_mac
    import dense_pkg::*;
#(
    parameter int BITSIZE = 32,
    parameter int ACC_W   = acc_width(32, 9)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      enable,
    input  logic signed [BITSIZE-1:0] a,
    input  logic signed [BITSIZE-1:0] b,
    output logic signed [ACC_W-1:0]   acc
);

    logic signed [2*BITSIZE-1:0] product;
    logic signed [ACC_W-1:0]     product_ext;

    always_comb begin
        // Widening casts of signed operands sign-extend before the multiply.
        product     = (2*BITSIZE)'(a) * (2*BITSIZE)'(b);
        product_ext = ACC_W'(product);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= enable ? product_ext : '0;
        end else if (enable) begin
            acc <= acc + product_ext;
        end
    end

endmodule

// File: rtl/dense_layer_seq.sv
// -----------------------------------------------------------------------------
// dense_layer_seq
// Sequential fixed-point dense layer: y[j] = act(sum_i x[i]*w[i][j] + b[j]),
// computed with one time-multiplexed MAC. Each neuron takes N_input MAC cycles
// plus one FINAL cycle (bias, round half up, saturate, activation), so the
// result is presented M_output*(N_input+1) cycles after the accept edge.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   x          in   N_input words, element i at word i
//   w          in   N_input*M_output words, w[i][j] at word j*N_input+i
//   b          in   M_output words, b[j] at word j
//   in_valid   in   operand set valid
//   in_ready   out  idle, operand set will be accepted
//   y          out  M_output result words, y[j] at word j
//   out_valid  out  y holds a complete result
//   out_ready  in   consumer takes y
//   busy       out  computation in progress
// -----------------------------------------------------------------------------
module dense_layer_seq
    import dense_pkg::*;
#(
    parameter int N_input  = 9,
    parameter int M_output = 4,
    parameter int BITSIZE  = 32,
    parameter int FRAC     = 16,
    parameter int ACT      = ACT_IDENTITY
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [N_input*BITSIZE-1:0]             x,
    input  logic [N_input*M_output*BITSIZE-1:0]    w,
    input  logic [M_output*BITSIZE-1:0]            b,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    output logic [M_output*BITSIZE-1:0]            y,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic                                   busy
);

    localparam int ACC_W = acc_width(BITSIZE, N_input);
    // Two extra bits absorb the bias and rounding additions without overflow.
    localparam int SUM_W = ACC_W + 2;
    localparam int I_W   = idx_width(N_input);
    localparam int J_W   = idx_width(M_output);
    localparam int W_W   = idx_width(N_input * M_output);

    localparam logic signed [SUM_W-1:0] ROUND_HALF =
        {{(SUM_W-1){1'b0}}, 1'b1} << (FRAC - 1);
    localparam logic signed [SUM_W-1:0] SAT_MAX =
        {{(SUM_W-BITSIZE+1){1'b0}}, {(BITSIZE-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN =
        {{(SUM_W-BITSIZE+1){1'b1}}, {(BITSIZE-1){1'b0}}};

    state_t                    state;
    logic [I_W-1:0]            i_cnt;
    logic [J_W-1:0]            j_cnt;
    logic [W_W-1:0]            w_idx;

    logic signed [BITSIZE-1:0] x_reg [N_input];
    logic signed [BITSIZE-1:0] w_reg [N_input*M_output];
    logic signed [BITSIZE-1:0] b_reg [M_output];
    logic signed [BITSIZE-1:0] y_reg [M_output];

    logic                      mac_clear;
    logic                      mac_enable;
    logic signed [ACC_W-1:0]   acc;

    logic signed [SUM_W-1:0]   bias_term;
    logic signed [SUM_W-1:0]   rounded;
    logic signed [SUM_W-1:0]   scaled;
    logic signed [BITSIZE-1:0] sat_val;
    logic signed [BITSIZE-1:0] act_val;

    // ------------------------------------------------------------------------
    // Operand capture. Only taken in IDLE, so input changes during a
    // computation are invisible to it.
    // NOTE: operand storage has no reset; it is always written on accept
    // before being read, and leaving it out of reset keeps it plain storage.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst && state == ST_IDLE && in_valid) begin
            for (int k = 0; k < N_input; k++) begin
                x_reg[k] <= x[k*BITSIZE +: BITSIZE];
            end
            for (int k = 0; k < N_input * M_output; k++) begin
                w_reg[k] <= w[k*BITSIZE +: BITSIZE];
            end
            for (int k = 0; k < M_output; k++) begin
                b_reg[k] <= b[k*BITSIZE +: BITSIZE];
            end
        end
    end

    // ------------------------------------------------------------------------
    // MAC datapath. The accumulator restarts on i == 0 of every neuron.
    // ------------------------------------------------------------------------
    always_comb begin
        w_idx      = W_W'(int'(j_cnt) * N_input + int'(i_cnt));
        mac_enable = (state == ST_MAC);
        mac_clear  = (state == ST_MAC) && (i_cnt == '0);
    end

    fixed_point_mac #(
        .BITSIZE (BITSIZE),
        .ACC_W   (ACC_W)
    ) u_mac (
        .clk    (clk),
        .rst    (rst),
        .clear  (mac_clear),
        .enable (mac_enable),
        .a      (x_reg[i_cnt]),
        .b      (w_reg[w_idx]),
        .acc    (acc)
    );

    // ------------------------------------------------------------------------
    // Output stage for neuron j_cnt, consumed in FINAL once the accumulator
    // holds all N_input products.
    // ------------------------------------------------------------------------
    // NOTE: every variable of an always_comb gets a value on every path, so
    // no latch is inferred.
    always_comb begin
        bias_term = SUM_W'(b_reg[j_cnt]) <<< FRAC;
        rounded   = SUM_W'(acc) + bias_term + ROUND_HALF;
        scaled    = rounded >>> FRAC;

        if (scaled > SAT_MAX) begin
            sat_val = SAT_MAX[BITSIZE-1:0];
        end else if (scaled < SAT_MIN) begin
            sat_val = SAT_MIN[BITSIZE-1:0];
        end else begin
            sat_val = scaled[BITSIZE-1:0];
        end

        act_val = sat_val;
        if (ACT == ACT_RELU && sat_val[BITSIZE-1]) begin
            act_val = '0;
        end
    end

    // ------------------------------------------------------------------------
    // Controller with registered handshake outputs.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            i_cnt     <= '0;
            j_cnt     <= '0;
            for (int k = 0; k < M_output; k++) begin
                y_reg[k] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        state    <= ST_MAC;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        i_cnt    <= '0;
                        j_cnt    <= '0;
                    end
                end

                ST_MAC: begin
                    if (i_cnt == I_W'(N_input - 1)) begin
                        state <= ST_FINAL;
                    end else begin
                        i_cnt <= i_cnt + 1'b1;
                    end
                end

                ST_FINAL: begin
                    y_reg[j_cnt] <= act_val;
                    if (j_cnt == J_W'(M_output - 1)) begin
                        state     <= ST_DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        state <= ST_MAC;
                        j_cnt <= j_cnt + 1'b1;
                        i_cnt <= '0;
                    end
                end

                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < M_output; g++) begin : g_y
        assign y[g*BITSIZE +: BITSIZE] = y_reg[g];
    end

endmodule

// File: tb/tb_dense_layer_seq.sv
// -----------------------------------------------------------------------------
// tb_dense_layer_seq
// Scoreboard bench for dense_layer_seq. The driver pushes the reference
// result of every accepted operand set; an independent monitor pops and
// compares whenever out_valid rises. A second, 1x1 ReLU instance covers the
// minimal configuration and the activation.
// -----------------------------------------------------------------------------
module tb_dense_layer_seq;

    localparam int N  = 9;
    localparam int M  = 4;
    localparam int B  = 32;
    localparam int FR = 16;
    localparam int LAT = M * (N + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [N*B-1:0]   x;
    logic [N*M*B-1:0] w;
    logic [M*B-1:0]   bias;
    logic             in_valid;
    logic             in_ready;
    logic [M*B-1:0]   y;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    dense_layer_seq #(
        .N_input(N), .M_output(M), .BITSIZE(B), .FRAC(FR), .ACT(0)
    ) dut (
        .clk(clk), .rst(rst), .x(x), .w(w), .b(bias),
        .in_valid(in_valid), .in_ready(in_ready),
        .y(y), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    logic [B-1:0] x1, w1, b1, y1;
    logic         iv1, ir1, ov1, busy1;
    logic         or1;

    dense_layer_seq #(
        .N_input(1), .M_output(1), .BITSIZE(B), .FRAC(FR), .ACT(1)
    ) dut_mini (
        .clk(clk), .rst(rst), .x(x1), .w(w1), .b(b1),
        .in_valid(iv1), .in_ready(ir1),
        .y(y1), .out_valid(ov1), .out_ready(or1), .busy(busy1)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [M*B-1:0] y;
        int             acc_cyc;
    } exp_t;
    exp_t sb[$];

    int             bp_mode = 0;   // 0: always ready, 1: random, 2: stalled
    logic [M*B-1:0] last_exp;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_neuron(input logic signed [127:0] dot,
                                               input logic [31:0] bv, input bit relu);
        logic signed [127:0] s;
        logic signed [127:0] bb;
        bb = $signed(bv);
        s  = dot + bb * 128'sd65536;
        s  = (s + 128'sd32768) >>> 16;   // floor((v + 0.5 LSB) / 2^16)
        if (s > 128'sd2147483647)       s = 128'sd2147483647;
        else if (s < -128'sd2147483648) s = -128'sd2147483648;
        if (relu && s < 0) s = '0;
        return s[31:0];
    endfunction

    function automatic logic [M*B-1:0] model_vec(input logic [N*B-1:0] xv,
                                                 input logic [N*M*B-1:0] wv,
                                                 input logic [M*B-1:0] bv);
        logic [M*B-1:0]      r;
        logic signed [127:0] d, t, u;
        for (int j = 0; j < M; j++) begin
            d = '0;
            for (int i = 0; i < N; i++) begin
                t = $signed(xv[i*B +: B]);
                u = $signed(wv[(j*N+i)*B +: B]);
                d = d + t * u;
            end
            r[j*B +: B] = ref_neuron(d, bv[j*B +: B], 1'b0);
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_word(input bit full);
        int v;
        if (full) return $urandom();
        v = int'($urandom_range(0, 32'h80000)) - 32'h40000;   // about +/-4.0
        return v;
    endfunction

    // ---------------- consumer backpressure ----------------
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (bp_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // ---------------- monitor ----------------
    logic           prev_ov = 1'b0;
    logic [M*B-1:0] held_y;
    logic           moved;
    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (out_valid && !prev_ov) begin
                check("out_valid_expected", out_valid, sb.size() != 0);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("y", y, e.y);
                    check("latency", cyc - e.acc_cyc, LAT);
                    last_exp = e.y;
                end
                held_y = y;
                moved  = 1'b0;
            end else if (out_valid && y !== held_y) begin
                moved = 1'b1;
            end
            if (!out_valid && prev_ov) check("y_hold", moved, 1'b0);
            prev_ov = out_valid;
        end
    end

    // ---------------- driver helpers (called at posedge+1) ----------------
    task automatic send(input logic [N*B-1:0] xv, input logic [N*M*B-1:0] wv,
                        input logic [M*B-1:0] bv);
        exp_t e;
        int   k;
        x = xv; w = wv; bias = bv; in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        check("in_ready_wait", in_ready, 1'b1);
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        e.y = model_vec(xv, wv, bv);
        @(posedge clk); #1;
        e.acc_cyc = cyc;
        sb.push_back(e);
        in_valid = 1'b0;
        // Scramble inputs: the captured operands must be unaffected.
        x = {N{32'($urandom())}}; w = {N*M{32'($urandom())}}; bias = {M{32'($urandom())}};
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (!(sb.size() == 0 && in_ready && !out_valid) && k < 5000) begin
            @(posedge clk); #1;
            k++;
        end
        check("drain", sb.size() == 0 && in_ready && !out_valid, 1'b1);
    endtask

    task automatic run_mini(input logic [31:0] xv, input logic [31:0] wv, input logic [31:0] bv);
        logic signed [127:0] d, t;
        int a, k;
        d = $signed(xv);
        t = $signed(wv);
        d = d * t;
        x1 = xv; w1 = wv; b1 = bv; iv1 = 1'b1;
        check("mini_in_ready", ir1, 1'b1);
        @(posedge clk); #1;
        a = cyc; iv1 = 1'b0;
        k = 0;
        while (!ov1 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("mini_latency", cyc - a, 2);
        check("mini_y", y1, ref_neuron(d, bv, 1'b1));
        @(posedge clk); #1;
        check("mini_idle", ir1, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    logic [N*B-1:0]   xv;
    logic [N*M*B-1:0] wv;
    logic [M*B-1:0]   bv;

    initial begin
        int k;
        rst = 1'b1; in_valid = 1'b0; x = '0; w = '0; bias = '0;
        iv1 = 1'b0; x1 = '0; w1 = '0; b1 = '0; or1 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_y", y, '0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1.0 * 0.5 summed over 9 inputs -> 4.5
        send({N{32'h00010000}}, {N*M{32'h00008000}}, '0);
        drain();
        check("y_4p5", y, {M{32'h00048000}});
        check("y_kept_in_idle", y, last_exp);

        // positive and negative saturation
        send({N{32'h00640000}}, {N*M{32'h00640000}}, '0);
        send({N{32'hFF9C0000}}, {N*M{32'h00640000}}, '0);
        drain();

        // half-LSB rounds up
        wv = '0;
        for (int j = 0; j < M; j++) wv[(j*N)*B +: B] = 32'h00008000;
        xv = '0; xv[B-1:0] = 32'h00000001;
        send(xv, wv, '0);
        drain();

        // random operand sets under random backpressure
        bp_mode = 1;
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < N; i++) xv[i*B +: B] = rand_word(n % 5 == 4);
            for (int i = 0; i < N*M; i++) wv[i*B +: B] = rand_word(n % 5 == 4);
            for (int j = 0; j < M; j++) bv[j*B +: B] = rand_word(n % 7 == 6);
            send(xv, wv, bv);
        end
        drain();

        // stall in DONE, pulse in_valid with new data: must be ignored
        bp_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) xv[i*B +: B] = rand_word(1'b0);
        for (int i = 0; i < N*M; i++) wv[i*B +: B] = rand_word(1'b0);
        send(xv, wv, {M{32'h00020000}});
        k = 0;
        while (!out_valid && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check("stall_reached_done", out_valid, 1'b1);
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin
                x = {N{32'h00030000}}; w = {N*M{32'h00010000}}; in_valid = 1'b1;
                check("in_ready_in_done", in_ready, 1'b0);
            end
            if (c == 4) in_valid = 1'b0;
            @(posedge clk); #1;
        end
        check("stall_still_valid", out_valid, 1'b1);
        bp_mode = 0;
        k = 0;
        while (out_valid && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        check("idle_after_ack", in_ready, 1'b1);
        check("ignored_no_pending", sb.size(), 0);

        // reset 15 cycles into a computation
        send({N{32'h00010000}}, {N*M{32'h00010000}}, {M{32'h00010000}});
        repeat (14) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_y", y, '0);
        check("midrst_in_ready", in_ready, 1'b1);
        sb.delete();
        rst = 1'b0;
        @(posedge clk); #1;
        send({N{32'h00020000}}, {N*M{32'hFFFF8000}}, {M{32'h00010000}});
        drain();

        // 1x1 ReLU instance
        run_mini(32'h00640000, 32'h00640000, 32'h0);
        run_mini(32'hFF9C0000, 32'h00640000, 32'h0);
        run_mini(32'h00000001, 32'h00008000, 32'h0);
        run_mini(32'h00018000, 32'hFFFE0000, 32'h00010000);
        for (int n = 0; n < 4; n++) run_mini(rand_word(1'b0), rand_word(1'b0), rand_word(1'b0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
